// File: rtl/demux_1x16_collector.sv
// demux_1x16_collector: registered 1-to-16 bit steering demux / word collector.
// Optional DEMUX_PARITY_EN adds out_parity (= ^out, registered with out).
module demux_1x16_collector #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel_mode,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dup_err
`ifdef DEMUX_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     asm_q;
  logic [N-1:0]     mask_q;
  logic [N-1:0]     asm_nxt;
  logic [N-1:0]     mask_nxt;
  logic [N-1:0]     onehot;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] idx;
  logic             mode_q;
  logic             mode_eff;
  logic             acc;
  logic             done;
  logic             dup;
  logic             deliver;

  assign in_ready  = (state != HOLD) & ~rst;
  assign out_valid = (state == HOLD);
  assign acc       = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  // The mode is taken live on the first bit of a word, latched afterwards.
  always_comb begin
    mode_eff = (state == IDLE) ? sel_mode : mode_q;
    idx      = mode_eff ? ptr_q : sel;
    onehot   = N'(1) << idx;
    asm_nxt  = in_bit ? (asm_q | onehot) : (asm_q & ~onehot);
    mask_nxt = mask_q | onehot;
    dup      = ~mode_eff & (|(mask_q & onehot));
    done     = mode_eff ? (ptr_q == SEL_W'(N - 1)) : (&mask_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (acc) state_nxt = done ? HOLD : COLLECT;
      end
      COLLECT: begin
        if (acc && done) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q   <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      mode_q  <= 1'b0;
      out     <= '0;
      dup_err <= 1'b0;
    end else begin
      dup_err <= acc & dup;
      if (acc) begin
        if (state == IDLE) mode_q <= sel_mode;
        asm_q  <= asm_nxt;
        mask_q <= mask_nxt;
        if (mode_eff) ptr_q <= ptr_q + 1'b1;
        if (done) out <= asm_nxt;
      end else if (deliver) begin
        asm_q  <= '0;
        mask_q <= '0;
        ptr_q  <= '0;
      end
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              out_parity <= 1'b0;
    else if (acc && done) out_parity <= ^asm_nxt;
  end
`endif

endmodule

// File: tb/tb_demux_1x16_collector.sv
// Scoreboard bench for demux_1x16_collector.
// Define DEMUX_PARITY_EN to also check out_parity.
module tb_demux_1x16_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic        sel_mode;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        dup_err;
`ifdef DEMUX_PARITY_EN
  logic        out_parity;
`endif

  always #5 clk = ~clk;

  demux_1x16_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel_mode  (sel_mode),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dup_err   (dup_err)
`ifdef DEMUX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] sb_q[$];

  // reference model: one word = 16 writes of a bit array
  logic        m_started = 1'b0;
  logic        m_mode = 1'b0;
  logic [15:0] m_bits = '0;
  logic [15:0] m_fill = '0;
  int          m_pos = 0;
  logic        m_done;

  logic        exp_dup = 1'b0;
  logic        exp_rise = 1'b0;
  logic        exp_bubble = 1'b0;
  logic [15:0] last_word = '0;
  logic        prev_ov = 1'b0;
  logic        rise;
  logic [15:0] w;
  logic        rnd_ready = 1'b0;
  int          n;

  task automatic check(input logic ok, input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_fill    = '0;
    m_pos     = 0;
    sb_q.delete();
    last_word = '0;
    prev_ov   = 1'b0;
  endtask

  // sample handshakes just before each rising edge
  initial forever begin
    @(negedge clk);
    #4;
    exp_dup    = 1'b0;
    exp_rise   = 1'b0;
    exp_bubble = out_valid && out_ready && !rst;
    if (in_valid && in_ready) begin
      if (!m_started) begin
        m_started = 1'b1;
        m_mode    = sel_mode;
      end
      if (!m_mode) begin
        exp_dup      = m_fill[sel];
        m_bits[sel]  = in_bit;
        m_fill[sel]  = 1'b1;
        m_done       = (m_fill == 16'hFFFF);
      end else begin
        m_bits[m_pos] = in_bit;
        m_pos++;
        m_done = (m_pos == 16);
      end
      if (m_done) begin
        sb_q.push_back(m_bits);
        exp_rise  = 1'b1;
        m_started = 1'b0;
        m_fill    = '0;
        m_pos     = 0;
      end
    end
  end

  // monitor: compare on the falling edge
  initial forever begin
    @(negedge clk);
    rise = out_valid && !prev_ov;
    check(rise == exp_rise, "latency",
          16'(rise), 16'(exp_rise));
    if (rise) begin
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_word", out, 16'h0);
      end else begin
        w = sb_q.pop_front();
        check(out === w, "word", out, w);
        last_word = w;
`ifdef DEMUX_PARITY_EN
        check(out_parity === ^w, "parity",
              16'(out_parity), 16'(^w));
`endif
      end
    end else begin
      check(out === last_word, "out_hold", out, last_word);
    end
    if (out_valid)
      check(!in_ready, "in_ready_hold",
            16'(in_ready), 16'h0);
    if (exp_bubble)
      check(in_ready && !out_valid, "bubble",
            {14'h0, in_ready, out_valid}, 16'h2);
    check(dup_err === exp_dup, "dup_err",
          16'(dup_err), 16'(exp_dup));
    prev_ov = out_valid;
  end

  task automatic send(input logic m, input logic [3:0] s,
                      input logic b);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    sel_mode = m;
    sel      = s;
    in_bit   = b;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    #4;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      #4;
      k++;
    end
    check(in_ready, "send_timeout", 16'(in_ready), 16'h1);
    if (in_ready) @(posedge clk);
    else in_valid = 1'b0;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic seq_word(input logic [15:0] v);
    for (int i = 0; i < 16; i++)
      send(1'b1, 4'($urandom_range(0, 15)), v[i]);
  endtask

  task automatic release_word();
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(!out_valid, "release", 16'(out_valid), 16'h0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    sel_mode  = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check(out === 16'h0, "rst_out", out, 16'h0);
    check(out_valid === 1'b0, "rst_ov", 16'(out_valid), 16'h0);
    check(in_ready === 1'b0, "rst_ir", 16'(in_ready), 16'h0);
    check(dup_err === 1'b0, "rst_dup", 16'(dup_err), 16'h0);
    @(negedge clk);
    #2 rst = 1'b0;

    // sequential word 000D, held until released
    seq_word(16'h000D);
    idle(6);
    release_word();
    idle(2);

    // addressed, descending select
    out_ready = 1'b1;
    for (int s = 15; s >= 0; s--)
      send(1'b0, 4'(s), 1'(s & 1));
    idle(3);

    // addressed duplicate on bit 3
    send(1'b0, 4'd3, 1'b1);
    send(1'b0, 4'd3, 1'b0);
    for (int s = 0; s < 16; s++)
      if (s != 3) send(1'b0, 4'(s), 1'($urandom_range(0, 1)));
    idle(3);

    // hold with in_valid asserted, then one-bubble restart
    out_ready = 1'b0;
    seq_word(16'($urandom));
    @(negedge clk);
    in_valid = 1'b1;
    sel_mode = 1'b0;
    sel      = 4'd5;
    in_bit   = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    send(1'b0, 4'd5, 1'b1);
    for (int s = 0; s < 16; s++)
      if (s != 5) send(1'b1, 4'(s), 1'($urandom_range(0, 1)));
    idle(3);

    // reset mid-word
    for (int i = 0; i < 7; i++) send(1'b1, 4'd0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check(out === 16'h0, "midrst_out", out, 16'h0);
    check(out_valid === 1'b0, "midrst_ov", 16'(out_valid), 16'h0);
    check(in_ready === 1'b0, "midrst_ir", 16'(in_ready), 16'h0);
    check(dup_err === 1'b0, "midrst_dup", 16'(dup_err), 16'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    seq_word(16'h8421);
    idle(3);

    // parity words
    seq_word(16'h0007);
    idle(2);
    seq_word(16'h0003);
    idle(3);

    // random traffic
    rnd_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end
    rnd_ready = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(5);
    check(sb_q.size() == 0, "drain", 16'(sb_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
